// File: rtl/id_stage.sv
// RV32I decode stage with a 31-entry RAW scoreboard feeding the register bank.
// Optional same-cycle writeback bypass of the hazard check: define ID_WB_BYPASS_EN.
module id_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            instr_valid_in,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            instr_ready_out,
    input  logic            flush_in,
    output logic            out_valid_out,
    input  logic            out_ready_in,
    output logic [4:0]      srcA_out,
    output logic [4:0]      srcB_out,
    output logic [4:0]      dest_out,
    output logic            wb_en_out,
    output logic [XLEN-1:0] imm_out,
    output logic [XLEN-1:0] pc_out,
    output logic [2:0]      opclass_out,
    output logic [3:0]      funct_out,
    input  logic            wb_valid_in,
    input  logic [4:0]      wb_dest_in
);

    typedef enum logic [2:0] {
        CLS_ALU_R   = 3'd0,
        CLS_ALU_I   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_UPPER   = 3'd6,
        CLS_ILLEGAL = 3'd7
    } opclass_e;

    // One bit per architectural register x1..x31; x0 maps to an empty mask.
    function automatic logic [31:1] reg_mask(input logic [4:0] idx);
        logic [31:1] m;
        m = 31'd0;
        for (int i = 1; i < 32; i++) begin
            m[i] = (idx == 5'(i));
        end
        return m;
    endfunction

    opclass_e        cls_s;
    logic            use_a_s;
    logic            use_b_s;
    logic            writes_rd_s;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_s_fmt_s;
    logic [XLEN-1:0] imm_b_s;
    logic [XLEN-1:0] imm_u_s;
    logic [XLEN-1:0] imm_j_s;
    logic [4:0]      src_a_s;
    logic [4:0]      src_b_s;
    logic [4:0]      rd_s;
    logic            wb_en_s;
    logic [31:1]     byp_mask_s;
    logic            hazard_s;
    logic            accept_s;
    logic [31:1]     clr_wb_s;
    logic [31:1]     clr_kill_s;
    logic [31:1]     set_s;

    logic [31:1]     busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [4:0]      src_a_q, src_a_d;
    logic [4:0]      src_b_q, src_b_d;
    logic [4:0]      dest_q, dest_d;
    logic            wb_en_q, wb_en_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [2:0]      opclass_q, opclass_d;
    logic [3:0]      funct_q, funct_d;

    assign imm_i_s     = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
    assign imm_s_fmt_s = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b_s     = {{(XLEN-12){instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u_s     = {{(XLEN-32){instr_in[31]}}, instr_in[31:12], 12'h000};
    assign imm_j_s     = {{(XLEN-20){instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};

    // Opcode decode: class, which sources are read, rd write, immediate format.
    always_comb begin
        cls_s       = CLS_ILLEGAL;
        use_a_s     = 1'b0;
        use_b_s     = 1'b0;
        writes_rd_s = 1'b0;
        imm_s       = {XLEN{1'b0}};
        case (instr_in[6:0])
            7'b0110011: begin
                cls_s = CLS_ALU_R; use_a_s = 1'b1; use_b_s = 1'b1; writes_rd_s = 1'b1;
            end
            7'b0010011: begin
                cls_s = CLS_ALU_I; use_a_s = 1'b1; writes_rd_s = 1'b1; imm_s = imm_i_s;
            end
            7'b0000011: begin
                cls_s = CLS_LOAD; use_a_s = 1'b1; writes_rd_s = 1'b1; imm_s = imm_i_s;
            end
            7'b0100011: begin
                cls_s = CLS_STORE; use_a_s = 1'b1; use_b_s = 1'b1; imm_s = imm_s_fmt_s;
            end
            7'b1100011: begin
                cls_s = CLS_BRANCH; use_a_s = 1'b1; use_b_s = 1'b1; imm_s = imm_b_s;
            end
            7'b1101111: begin
                cls_s = CLS_JUMP; writes_rd_s = 1'b1; imm_s = imm_j_s;
            end
            7'b1100111: begin
                cls_s = CLS_JUMP; use_a_s = 1'b1; writes_rd_s = 1'b1; imm_s = imm_i_s;
            end
            7'b0110111, 7'b0010111: begin
                cls_s = CLS_UPPER; writes_rd_s = 1'b1; imm_s = imm_u_s;
            end
            default: begin
                cls_s = CLS_ILLEGAL;
            end
        endcase
    end

    assign rd_s    = instr_in[11:7];
    assign src_a_s = use_a_s ? instr_in[19:15] : 5'd0;
    assign src_b_s = use_b_s ? instr_in[24:20] : 5'd0;
    assign wb_en_s = writes_rd_s & (rd_s != 5'd0);

`ifdef ID_WB_BYPASS_EN
    assign byp_mask_s = wb_valid_in ? reg_mask(wb_dest_in) : 31'd0;
`else
    assign byp_mask_s = 31'd0;
`endif

    assign hazard_s = |((busy_q & ~byp_mask_s) & (reg_mask(src_a_s) | reg_mask(src_b_s)));

    assign instr_ready_out = rst_n_in & ~flush_in & ~hazard_s & (~out_valid_q | out_ready_in);
    assign accept_s        = instr_valid_in & instr_ready_out;

    // A flushed slot that never reached the bank must release its reservation.
    assign clr_wb_s   = wb_valid_in ? reg_mask(wb_dest_in) : 31'd0;
    assign clr_kill_s = (flush_in & out_valid_q & wb_en_q & ~out_ready_in) ? reg_mask(dest_q) : 31'd0;
    assign set_s      = (accept_s & wb_en_s) ? reg_mask(rd_s) : 31'd0;
    assign busy_d     = (busy_q & ~clr_wb_s & ~clr_kill_s) | set_s;

    // Output slot next state: flush kills, accept loads, drain empties, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        dest_d      = dest_q;
        wb_en_d     = wb_en_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        opclass_d   = opclass_q;
        funct_d     = funct_q;
        if (flush_in) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            src_a_d     = src_a_s;
            src_b_d     = src_b_s;
            dest_d      = rd_s;
            wb_en_d     = wb_en_s;
            imm_d       = imm_s;
            pc_d        = pc_in;
            opclass_d   = cls_s;
            funct_d     = {instr_in[30], instr_in[14:12]};
        end else if (out_ready_in) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            busy_q      <= 31'd0;
            out_valid_q <= 1'b0;
            src_a_q     <= 5'd0;
            src_b_q     <= 5'd0;
            dest_q      <= 5'd0;
            wb_en_q     <= 1'b0;
            imm_q       <= {XLEN{1'b0}};
            pc_q        <= {XLEN{1'b0}};
            opclass_q   <= 3'd0;
            funct_q     <= 4'd0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            dest_q      <= dest_d;
            wb_en_q     <= wb_en_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            opclass_q   <= opclass_d;
            funct_q     <= funct_d;
        end
    end

    assign out_valid_out = out_valid_q;
    assign srcA_out      = src_a_q;
    assign srcB_out      = src_b_q;
    assign dest_out      = dest_q;
    assign wb_en_out     = wb_en_q;
    assign imm_out       = imm_q;
    assign pc_out        = pc_q;
    assign opclass_out   = opclass_q;
    assign funct_out     = funct_q;

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage against a behavioural decode/scoreboard model.
module tb_id_stage;
    localparam int XLEN = 32;

    logic            clk_in = 1'b0;
    logic            rst_n_in, instr_valid_in, flush_in, out_ready_in, wb_valid_in;
    logic [31:0]     instr_in;
    logic [XLEN-1:0] pc_in;
    logic [4:0]      wb_dest_in;
    logic            instr_ready_out, out_valid_out, wb_en_out;
    logic [4:0]      srcA_out, srcB_out, dest_out;
    logic [XLEN-1:0] imm_out, pc_out;
    logic [2:0]      opclass_out;
    logic [3:0]      funct_out;

    always #5 clk_in = ~clk_in;

    id_stage #(.XLEN(XLEN)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .instr_valid_in(instr_valid_in),
        .instr_in(instr_in), .pc_in(pc_in), .instr_ready_out(instr_ready_out),
        .flush_in(flush_in), .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
        .srcA_out(srcA_out), .srcB_out(srcB_out), .dest_out(dest_out),
        .wb_en_out(wb_en_out), .imm_out(imm_out), .pc_out(pc_out),
        .opclass_out(opclass_out), .funct_out(funct_out),
        .wb_valid_in(wb_valid_in), .wb_dest_in(wb_dest_in)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  d;
        logic        we;
        logic [31:0] imm;
        logic [2:0]  cls;
        logic [3:0]  funct;
        logic [31:0] pc;
    } slot_t;

    int    checks = 0;
    int    errors = 0;
    bit    mbusy[32];
    logic  mvalid = 1'b0;
    slot_t mslot = '0;
    logic  ready_seen;

    // Instruction meaning straight from the ISA tables.
    function automatic slot_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        slot_t s;
        logic [6:0] op;
        bit ra, rb;
        logic [31:0] imm;
        op = ins[6:0];
        s = '0;
        s.d = ins[11:7];
        s.funct = {ins[30], ins[14:12]};
        s.pc = pc;
        s.cls = 3'd7;
        ra = 0; rb = 0; imm = 32'd0;
        if (op == 7'h33) begin s.cls = 3'd0; ra = 1; rb = 1; end
        else if (op == 7'h13) begin s.cls = 3'd1; ra = 1; imm = $signed(ins[31:20]); end
        else if (op == 7'h03) begin s.cls = 3'd2; ra = 1; imm = $signed(ins[31:20]); end
        else if (op == 7'h23) begin s.cls = 3'd3; ra = 1; rb = 1; imm = $signed({ins[31:25], ins[11:7]}); end
        else if (op == 7'h63) begin s.cls = 3'd4; ra = 1; rb = 1;
            imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); end
        else if (op == 7'h6F) begin s.cls = 3'd5;
            imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); end
        else if (op == 7'h67) begin s.cls = 3'd5; ra = 1; imm = $signed(ins[31:20]); end
        else if (op == 7'h37 || op == 7'h17) begin s.cls = 3'd6; imm = {ins[31:12], 12'h000}; end
        s.a = ra ? ins[19:15] : 5'd0;
        s.b = rb ? ins[24:20] : 5'd0;
        s.imm = imm;
        s.we = (s.cls inside {3'd0, 3'd1, 3'd2, 3'd5, 3'd6}) && (s.d != 5'd0);
        return s;
    endfunction

    function automatic bit bypassed(input logic [4:0] idx, input logic wbv, input logic [4:0] wbd);
`ifdef ID_WB_BYPASS_EN
        return wbv && (wbd == idx);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle, check ready before the edge and every slot field after it.
    task automatic step(input logic rst, input logic iv, input logic [31:0] ins, input logic fl,
                        input logic ordy, input logic wbv, input logic [4:0] wbd);
        slot_t dec;
        logic  haz, exp_rdy, acc;
        logic [31:0] pc;
        pc = $urandom;
        rst_n_in = rst; instr_valid_in = iv; instr_in = ins; pc_in = pc;
        flush_in = fl; out_ready_in = ordy; wb_valid_in = wbv; wb_dest_in = wbd;
        @(negedge clk_in);
        dec = model_decode(ins, pc);
        haz = ((dec.a != 5'd0) && mbusy[dec.a] && !bypassed(dec.a, wbv, wbd)) ||
              ((dec.b != 5'd0) && mbusy[dec.b] && !bypassed(dec.b, wbv, wbd));
        exp_rdy = rst && !fl && !haz && (!mvalid || ordy);
        ready_seen = instr_ready_out;
        chk("instr_ready", {31'd0, instr_ready_out}, {31'd0, exp_rdy});
        acc = iv && exp_rdy;
        if (!rst) begin
            for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
            mvalid = 1'b0;
            mslot = '0;
        end else begin
            if (wbv && wbd != 5'd0) mbusy[wbd] = 1'b0;
            if (fl && mvalid && mslot.we && !ordy) mbusy[mslot.d] = 1'b0;
            if (acc && dec.we) mbusy[dec.d] = 1'b1;
            if (fl) mvalid = 1'b0;
            else if (acc) begin mslot = dec; mvalid = 1'b1; end
            else if (ordy) mvalid = 1'b0;
        end
        @(posedge clk_in);
        #1;
        chk("out_valid", {31'd0, out_valid_out}, {31'd0, mvalid});
        chk("srcA", {27'd0, srcA_out}, {27'd0, mslot.a});
        chk("srcB", {27'd0, srcB_out}, {27'd0, mslot.b});
        chk("dest", {27'd0, dest_out}, {27'd0, mslot.d});
        chk("wb_en", {31'd0, wb_en_out}, {31'd0, mslot.we});
        chk("imm", imm_out, mslot.imm);
        chk("pc", pc_out, mslot.pc);
        chk("opclass", {29'd0, opclass_out}, {29'd0, mslot.cls});
        chk("funct", {28'd0, funct_out}, {28'd0, mslot.funct});
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  op;
        ins = $urandom;
        case ($urandom_range(10))
            0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h23;
            4: op = 7'h63;  5: op = 7'h6F;  6: op = 7'h67;  7: op = 7'h37;
            8: op = 7'h17;  9: op = 7'h33;
            default: op = 7'(ins[6:0]);
        endcase
        ins[6:0] = op;
        ins[11:10] = 2'b00;
        ins[19:18] = 2'b00;
        ins[24:23] = 2'b00;
        return ins;
    endfunction

    initial begin
        step(1'b0, 1'b0, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 5'd0);
        chk("rst_ready", {31'd0, ready_seen}, 32'd0);
        chk("rst_valid", {31'd0, out_valid_out}, 32'd0);
        chk("rst_imm", imm_out, 32'd0);

        step(1'b1, 1'b1, 32'h0031_02B3, 1'b0, 1'b1, 1'b0, 5'd0);
        chk("add_valid", {31'd0, out_valid_out}, 32'd1);
        chk("add_srcA", {27'd0, srcA_out}, 32'd2);
        chk("add_srcB", {27'd0, srcB_out}, 32'd3);
        chk("add_dest", {27'd0, dest_out}, 32'd5);
        chk("add_wb_en", {31'd0, wb_en_out}, 32'd1);
        chk("add_opclass", {29'd0, opclass_out}, 32'd0);
        chk("add_funct", {28'd0, funct_out}, 32'd0);

        step(1'b1, 1'b1, 32'h0012_8313, 1'b0, 1'b1, 1'b0, 5'd0);
        chk("raw_stall", {31'd0, ready_seen}, 32'd0);
        step(1'b1, 1'b1, 32'h0012_8313, 1'b0, 1'b1, 1'b1, 5'd5);
`ifdef ID_WB_BYPASS_EN
        chk("wb_cycle_ready", {31'd0, ready_seen}, 32'd1);
`else
        chk("wb_cycle_ready", {31'd0, ready_seen}, 32'd0);
        step(1'b1, 1'b1, 32'h0012_8313, 1'b0, 1'b1, 1'b0, 5'd0);
        chk("after_wb_ready", {31'd0, ready_seen}, 32'd1);
`endif
        chk("addi_srcA", {27'd0, srcA_out}, 32'd5);
        chk("addi_srcB", {27'd0, srcB_out}, 32'd0);
        chk("addi_imm", imm_out, 32'd1);
        chk("addi_dest", {27'd0, dest_out}, 32'd6);

        step(1'b1, 1'b1, 32'hFFF0_0093, 1'b0, 1'b1, 1'b0, 5'd0);
        chk("neg_imm", imm_out, 32'hFFFF_FFFF);
        chk("neg_opclass", {29'd0, opclass_out}, 32'd1);
        step(1'b1, 1'b1, 32'h0031_2423, 1'b0, 1'b1, 1'b0, 5'd0);
        chk("sw_imm", imm_out, 32'd8);
        chk("sw_srcB", {27'd0, srcB_out}, 32'd3);
        chk("sw_wb_en", {31'd0, wb_en_out}, 32'd0);
        chk("sw_opclass", {29'd0, opclass_out}, 32'd3);
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd0);
        chk("ill_ready", {31'd0, ready_seen}, 32'd1);
        chk("ill_opclass", {29'd0, opclass_out}, 32'd7);
        chk("ill_imm", imm_out, 32'd0);

        step(1'b1, 1'b1, 32'h0031_03B3, 1'b0, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 5'd0);
            chk("hold_ready", {31'd0, ready_seen}, 32'd0);
            chk("hold_dest", {27'd0, dest_out}, 32'd7);
            chk("hold_valid", {31'd0, out_valid_out}, 32'd1);
        end
        step(1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 5'd0);
        chk("flush_valid", {31'd0, out_valid_out}, 32'd0);
        step(1'b1, 1'b1, 32'h0003_8413, 1'b0, 1'b1, 1'b0, 5'd0);
        chk("flush_freed_x7", {31'd0, ready_seen}, 32'd1);

        step(1'b1, 1'b1, 32'h0031_02B3, 1'b0, 1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b1, 32'h0031_02B3, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("rst2_valid", {31'd0, out_valid_out}, 32'd0);
        step(1'b1, 1'b1, 32'h0012_8313, 1'b0, 1'b1, 1'b0, 5'd0);
        chk("rst2_x5_free", {31'd0, ready_seen}, 32'd1);
        chk("rst2_srcA", {27'd0, srcA_out}, 32'd5);

        for (int n = 0; n < 4000; n++) begin
            step(($urandom_range(99) != 0), ($urandom_range(9) < 8), rand_instr(),
                 ($urandom_range(19) == 0), ($urandom_range(9) < 7),
                 ($urandom_range(9) < 4), 5'($urandom_range(7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage directly upstream of the register bank.
- Accepts fetched RV32I instruction words and extracts source/destination register indices, immediate, and operation class into a registered output slot.
- Output slot drives the bank's srcA/srcB/dest and write enable.
- A 31-entry scoreboard stalls read-after-write hazards until the producing instruction's writeback returns.

Parameters:
XLEN, 32, data/immediate/PC width; equals `DATA_WIDTH from defs.vh.

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  reset, synchronous, active-low
instr_valid_in  input  1  fetch offers instr_in/pc_in
instr_in  input  32  instruction word
pc_in  input  XLEN  instruction address
instr_ready_out  output  1  stage accepts the offered instruction this cycle
flush_in  input  1  kill output slot, refuse input this cycle
out_valid_out  output  1  output slot holds a decoded instruction
out_ready_in  input  1  downstream consumes the slot
srcA_out  output  5  rs1 index (0 if unused)
srcB_out  output  5  rs2 index (0 if unused)
dest_out  output  5  rd index
wb_en_out  output  1  instruction writes rd (rd!=0)
imm_out  output  XLEN  sign-extended immediate
pc_out  output  XLEN  registered pc_in
opclass_out  output  3  0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 6 UPPER, 7 ILLEGAL
funct_out  output  4  {instr[30], instr[14:12]}
wb_valid_in  input  1  writeback completing this cycle
wb_dest_in  input  5  register written by that writeback

Behaviour:
- Reset (rst_n_in=0 at a clk_in edge) clears all registered outputs to 0, including out_valid_out.
  - Clears all busy bits.
  - Has priority over every other input.
  - instr_ready_out is 0 while rst_n_in=0.
- Opcode decode:
  - 0110011 -> ALU_R.
  - 0010011 -> ALU_I.
  - 0000011 -> LOAD.
  - 0100011 -> STORE.
  - 1100011 -> BRANCH.
  - 1101111/1100111 -> JUMP.
  - 0110111/0010111 -> UPPER.
  - Anything else -> ILLEGAL: wb_en=0, srcA=srcB=0, imm=0.
- Source register use:
  - srcA valid for R/I/LOAD/STORE/BRANCH/JALR.
  - srcB valid for R/STORE/BRANCH.
  - Unused sources are forced to 0.
- wb_en = class in {ALU_R, ALU_I, LOAD, JUMP, UPPER} and rd != 0.
- Immediate formats:
  - I: instr[31:20].
  - S: {31:25, 11:7}.
  - B: {31, 7, 30:25, 11:8, 0}.
  - U: {31:12, 12'b0}.
  - J: {31, 19:12, 20, 30:21, 0}.
  - All sign-extended from instr[31] to XLEN.
- Hazard: decoded srcA != 0 and busy[srcA], or decoded srcB != 0 and busy[srcB]. x0 is never busy.
- instr_ready_out = rst_n_in & !flush_in & !hazard & (!out_valid_out | out_ready_in). Combinational.
- Accept when instr_valid_in & instr_ready_out. Next edge: output slot loads the decoded fields and out_valid_out=1. Latency is 1 cycle.
- Slot drained (out_ready_in & out_valid_out) with no accept: out_valid_out -> 0 next edge. Fields hold their last values.
- No drain and no accept: slot holds all fields stable (valid/ready handshake, no bubbles inserted while valid).
- Scoreboard:
  - On accept with wb_en: busy[rd] set next edge.
  - On wb_valid_in with wb_dest_in != 0: busy[wb_dest_in] cleared next edge.
  - Same register set and cleared in the same cycle: set wins (newer producer).
  - Clear is visible to the hazard check only from the following cycle, unless the optional feature is enabled.
- Flush:
  - Slot invalidated next edge.
  - If the killed slot had wb_en_out=1 and was not drained that cycle, busy[dest_out] is cleared, unless the same register is simultaneously being set (impossible: flush blocks accept).
  - Busy bits of already-drained instructions are untouched.
- Full pipeline: downstream stalled (out_ready_in=0) with a valid slot -> no accept, hazard irrelevant.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: a same-cycle wb_valid_in/wb_dest_in matching a source masks that source's busy bit in the hazard check. The stall releases in the writeback cycle. Valid only if the regbank's write-then-read timing is honoured downstream.
- Undefined: hazard uses registered busy only; stall releases one cycle after writeback.

Test Plan:
- Reset with rst_n_in=0, then offer 0x003102B3 (add x5,x2,x3) with out_ready_in=1 -> next cycle out_valid=1, srcA=2, srcB=3, dest=5, wb_en=1, opclass=0, funct=0; busy[5]=1.
- 0x003102B3 then 0x00128313 (addi x6,x5,1) -> second instruction stalled with instr_ready_out=0. wb_valid_in=1, wb_dest_in=5 -> accepted the cycle after writeback, or the same cycle with ID_WB_BYPASS_EN. Then srcA=5, srcB=0, imm=1, dest=6.
- 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, srcA=0, dest=1, opclass=1. 0x00312423 (sw x3,8(x2)) -> imm=8, srcA=2, srcB=3, wb_en=0, opclass=3, no busy change.
- 0xFFFFFFFF -> opclass=7, wb_en=0, srcA=srcB=0, imm=0, no stall.
- out_ready_in=0 for 3 cycles with a valid slot, then a flush_in pulse -> outputs stable and instr_ready_out=0 while held. Flush clears out_valid and the busy bit of the killed dest.
- rst_n_in=0 while busy[5]=1 and the slot is valid -> next edge out_valid=0, all busy clear; an instruction reading x5 is accepted immediately after reset.
